// File: rtl/apb_ic_pkg.sv
// Shared types, default widths and address decode for the APB round-robin interconnect.
package apb_ic_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam int unsigned NM_DEF    = 4;
  localparam int unsigned SW        = $clog2(NM_DEF);
  localparam int unsigned DEC_W_DEF = 4;
  localparam int unsigned DEC_MAX_W = 8;

  typedef struct packed {
    logic [DEC_MAX_W-1:0] idx;
    logic                 err;
  } dec_t;

  // Completer index taken from the top address bits; err flags an index with no completer behind it.
  function automatic dec_t decode(input logic [DEC_MAX_W-1:0] field, input int unsigned ns);
    dec_t d;
    d.idx = field;
    d.err = (32'(field) >= ns);
    return d;
  endfunction

endpackage

// File: rtl/apb_rr_interconnect_if.sv
// Requester-side and completer-side APB bundles of the interconnect.
interface apb_rr_interconnect_if #(
  parameter int unsigned NM = 4,
  parameter int unsigned NS = 4,
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  localparam int unsigned SBW = DW / 8;

  logic [NM-1:0]                PSEL;
  logic [NM-1:0]                PENABLE;
  logic [NM-1:0]                PWRITE;
  logic [NM-1:0][AW-1:0]        PADDR;
  logic [NM-1:0][DW-1:0]        PWDATA;
  logic [NM-1:0][SBW-1:0]       PSTRB;
  logic [NM-1:0]                PREADY;
  logic [NM-1:0][DW-1:0]        PRDATA;
  logic [NM-1:0]                PSLVERR;
  logic [NM-1:0]                PGRANT;

  logic [NS-1:0]                PSEL_S;
  logic [NS-1:0]                PENABLE_S;
  logic [NS-1:0]                PWRITE_S;
  logic [NS-1:0][AW-1:0]        PADDR_S;
  logic [NS-1:0][DW-1:0]        PWDATA_S;
  logic [NS-1:0][SBW-1:0]       PSTRB_S;
  logic [NS-1:0][DW-1:0]        PRDATA_S;
  logic [NS-1:0]                PREADY_S;
  logic [NS-1:0]                PSLVERR_S;

  // master: the requesters and completers around the interconnect; slave: the interconnect itself
  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PREADY, PRDATA, PSLVERR, PGRANT,
    input  PSEL_S, PENABLE_S, PWRITE_S, PADDR_S, PWDATA_S, PSTRB_S,
    output PRDATA_S, PREADY_S, PSLVERR_S
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PREADY, PRDATA, PSLVERR, PGRANT,
    output PSEL_S, PENABLE_S, PWRITE_S, PADDR_S, PWDATA_S, PSTRB_S,
    input  PRDATA_S, PREADY_S, PSLVERR_S
  );
endinterface

// File: rtl/apb_rr_arbiter.sv
// Round-robin pick of the first requester at or after the pointer.
module apb_rr_arbiter #(
  parameter  int unsigned NM = 4,
  localparam int unsigned IW = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic [NM-1:0] req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [NM-1:0] grant,
  output logic [IW-1:0] idx,
  output logic          valid
);

  always_comb begin
    int unsigned j;
    j     = 0;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < NM; i++) begin
      j = (32'(ptr) + i) % NM;
      if (en && !valid && req[j]) begin
        valid    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/apb_rr_interconnect.sv
// NM-requester to NS-completer APB interconnect with round-robin grant, decode error and timeout.
module apb_rr_interconnect
  import apb_ic_pkg::*;
#(
  parameter int unsigned NM      = 4,
  parameter int unsigned NS      = 4,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned DEC_W   = DEC_W_DEF,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic PCLK,
  input  logic PRST,
  apb_rr_interconnect_if.slave bus
);

  localparam int unsigned GW  = (NM > 1) ? $clog2(NM) : 1;
  localparam int unsigned SSW = (NS > 1) ? $clog2(NS) : 1;
  localparam int unsigned CW  = $clog2(TIMEOUT + 1);

  state_t          state;
  logic [NM-1:0]   grant_q;
  logic [GW-1:0]   g_q;
  logic [GW-1:0]   ptr_q;
  logic [DEC_W-1:0] s_q;
  logic            err_q;
  logic [CW-1:0]   cnt_q;

  logic [NM-1:0]   arb_grant;
  logic [GW-1:0]   arb_idx;
  logic            arb_valid;
  dec_t            dec_c;
  logic [SSW-1:0]  s_sel;
  logic            ready_s;
  logic            tmo;
  logic            done;
  logic            unused_bits;

  apb_rr_arbiter #(.NM(NM)) u_arb (
    .req   (bus.PSEL),
    .ptr   (ptr_q),
    .en    (state == IDLE),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign dec_c       = decode(DEC_MAX_W'(bus.PADDR[arb_idx][AW-1 -: DEC_W]), NS);
  assign s_sel       = SSW'(s_q);
  assign ready_s     = !err_q && bus.PREADY_S[s_sel];
  assign tmo         = (cnt_q == CW'(TIMEOUT - 1));
  assign done        = (state == ACCESS) && (err_q || ready_s || tmo);
  assign bus.PGRANT  = grant_q;
  // PENABLE is not needed: sequencing towards completers is generated here
  assign unused_bits = ^{bus.PENABLE, dec_c.idx};

  // Arbitration, transfer sequencing and wait-state timeout
  always_ff @(posedge PCLK) begin
    if (PRST) begin
      state   <= IDLE;
      grant_q <= '0;
      g_q     <= '0;
      ptr_q   <= '0;
      s_q     <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            grant_q <= arb_grant;
            g_q     <= arb_idx;
            s_q     <= dec_c.idx[DEC_W-1:0];
            err_q   <= dec_c.err;
            state   <= SETUP;
          end
        end
        SETUP: state <= ACCESS;
        ACCESS: begin
          if (done) begin
            state   <= IDLE;
            grant_q <= '0;
            cnt_q   <= '0;
            ptr_q   <= (g_q == GW'(NM - 1)) ? '0 : g_q + GW'(1);
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Completer select/forwarding and the response path back to the granted requester
  always_comb begin
    bus.PSEL_S    = '0;
    bus.PENABLE_S = '0;
    bus.PWRITE_S  = '0;
    bus.PADDR_S   = '0;
    bus.PWDATA_S  = '0;
    bus.PSTRB_S   = '0;
    bus.PREADY    = '0;
    bus.PSLVERR   = '0;
    bus.PRDATA    = '0;
    if (state != IDLE) begin
      if (!err_q) begin
        bus.PSEL_S[s_sel]    = 1'b1;
        bus.PENABLE_S[s_sel] = (state == ACCESS);
      end
      for (int unsigned k = 0; k < NS; k++) begin
        bus.PWRITE_S[k] = bus.PWRITE[g_q];
        bus.PADDR_S[k]  = bus.PADDR[g_q];
        bus.PWDATA_S[k] = bus.PWDATA[g_q];
        bus.PSTRB_S[k]  = bus.PSTRB[g_q];
      end
    end
    if (done) begin
      bus.PREADY[g_q]  = 1'b1;
      bus.PSLVERR[g_q] = !ready_s || bus.PSLVERR_S[s_sel];
      if (ready_s && !bus.PWRITE[g_q]) begin
        bus.PRDATA[g_q] = bus.PRDATA_S[s_sel];
      end
    end
  end

endmodule

// File: tb/tb_apb_rr_interconnect.sv
// Self-checking bench: directed vector table, round-robin/reset sequences and randomized rounds.
module tb_apb_rr_interconnect;
  localparam int unsigned NM = 4;
  localparam int unsigned NS = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned DEC_W = 4;
  localparam int unsigned TIMEOUT = 16;

  logic PCLK = 1'b0;
  logic PRST;
  always #5 PCLK = ~PCLK;

  apb_rr_interconnect_if #(.NM(NM), .NS(NS), .AW(AW), .DW(DW)) bus ();

  apb_rr_interconnect #(
    .NM(NM), .NS(NS), .AW(AW), .DW(DW), .DEC_W(DEC_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .PCLK (PCLK),
    .PRST (PRST),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;

  // Completer models: ready after wait_n not-ready ACCESS cycles
  int unsigned wait_n [NS];
  logic [DW-1:0] rd_val [NS];
  logic se_val [NS];
  int unsigned acc_cnt [NS];

  always @(posedge PCLK) begin
    for (int k = 0; k < NS; k++) begin
      if (bus.PSEL_S[k] && bus.PENABLE_S[k]) acc_cnt[k] <= acc_cnt[k] + 1;
      else acc_cnt[k] <= 0;
    end
  end

  always_comb begin
    for (int k = 0; k < NS; k++) begin
      bus.PREADY_S[k]  = bus.PSEL_S[k] && bus.PENABLE_S[k] && (acc_cnt[k] >= wait_n[k]);
      bus.PRDATA_S[k]  = rd_val[k];
      bus.PSLVERR_S[k] = se_val[k];
    end
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int unsigned r;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int unsigned wt;
    logic [31:0] rdata;
    logic        sev;
    logic [3:0]  exp_psel_s;
    int unsigned exp_lat;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  task automatic run_vec(input vec_t v);
    int unsigned s;
    int lat;
    bit seen;
    s = int'(v.addr[31:28]);
    if (s < NS) begin
      wait_n[s] = v.wt;
      rd_val[s] = v.rdata;
      se_val[s] = v.sev;
    end
    bus.PWRITE[v.r] = v.wr;
    bus.PADDR[v.r]  = v.addr;
    bus.PWDATA[v.r] = v.wdata;
    bus.PSTRB[v.r]  = v.strb;
    bus.PSEL        = '0;
    bus.PSEL[v.r]   = 1'b1;
    tick();
    chk("vec_pgrant", 128'(bus.PGRANT), 128'(4'b0001 << v.r));
    chk("vec_setup_psel_s", 128'(bus.PSEL_S), 128'(v.exp_psel_s));
    chk("vec_setup_penable_s", 128'(bus.PENABLE_S), 128'(0));
    chk("vec_pstrb_s", 128'(bus.PSTRB_S[0]), 128'(v.strb));
    chk("vec_paddr_s", 128'(bus.PADDR_S[NS-1]), 128'(v.addr));
    bus.PENABLE[v.r] = 1'b1;
    lat  = 1;
    seen = 0;
    while (!seen && lat < 40) begin
      tick();
      lat++;
      if (bus.PREADY != '0) seen = 1;
    end
    chk("vec_latency", 128'(lat), 128'(v.exp_lat));
    chk("vec_pready", 128'(bus.PREADY), 128'(4'b0001 << v.r));
    chk("vec_pslverr", 128'(bus.PSLVERR), 128'(v.exp_err) << v.r);
    chk("vec_prdata", 128'(bus.PRDATA), 128'(v.exp_rdata) << (32 * v.r));
    bus.PSEL    = '0;
    bus.PENABLE = '0;
    tick();
  endtask

  // Reference model state for the randomized rounds
  logic [31:0] r_addr [NM];
  logic        r_wr   [NM];
  int unsigned mptr;

  function automatic int unsigned next_req(input logic [3:0] p, input int unsigned ptr);
    for (int unsigned i = 0; i < NM; i++) begin
      if (p[(ptr + i) % NM]) return (ptr + i) % NM;
    end
    return 0;
  endfunction

  // ACCESS cycles a transfer occupies: 1 on decode error, otherwise waits+1 capped at TIMEOUT
  function automatic int unsigned acc_of(input int unsigned e);
    int unsigned s;
    s = int'(r_addr[e][31:28]);
    if (s >= NS) return 1;
    return (wait_n[s] + 1 < TIMEOUT) ? wait_n[s] + 1 : TIMEOUT;
  endfunction

  initial begin
    logic [3:0] pend;
    int unsigned e, cyc, exp_cyc, n, s;
    logic exp_err;
    logic [31:0] exp_rd;

    PRST = 1'b1;
    bus.PSEL = '0; bus.PENABLE = '0; bus.PWRITE = '0;
    bus.PADDR = '0; bus.PWDATA = '0; bus.PSTRB = '0;
    for (int k = 0; k < NS; k++) begin
      wait_n[k] = 0; rd_val[k] = '0; se_val[k] = 1'b0;
    end
    tick(); tick();
    chk("rst_pgrant", 128'(bus.PGRANT), 128'(0));
    chk("rst_psel_s", 128'(bus.PSEL_S), 128'(0));
    chk("rst_penable_s", 128'(bus.PENABLE_S), 128'(0));
    chk("rst_pready", 128'(bus.PREADY), 128'(0));
    chk("rst_pslverr", 128'(bus.PSLVERR), 128'(0));
    chk("rst_prdata", 128'(bus.PRDATA), 128'(0));
    PRST = 1'b0;
    tick();

    //            r  wr  addr          wdata  strb  wt   rdata  sev psel_s lat err rdata
    vecs[0] = '{2, 1'b1, 32'h1000_0004, 32'hA, 4'b0010, 0,  32'h77, 1'b0, 4'b0010, 2,  1'b0, 32'h0};
    vecs[1] = '{1, 1'b0, 32'h3000_0000, 32'h0, 4'b1111, 3,  32'hB,  1'b0, 4'b1000, 5,  1'b0, 32'hB};
    vecs[2] = '{0, 1'b0, 32'h7000_0003, 32'h0, 4'b1111, 0,  32'h0,  1'b0, 4'b0000, 2,  1'b1, 32'h0};
    vecs[3] = '{3, 1'b0, 32'h2000_0010, 32'h0, 4'b1111, 255, 32'hCC, 1'b0, 4'b0100, 17, 1'b1, 32'h0};
    vecs[4] = '{0, 1'b0, 32'h0000_0000, 32'h0, 4'b1111, 1,  32'h55, 1'b1, 4'b0001, 3,  1'b1, 32'h55};
    vecs[5] = '{3, 1'b1, 32'h2000_0000, 32'h5, 4'b1001, 15, 32'hDD, 1'b0, 4'b0100, 17, 1'b0, 32'h0};
    vecs[6] = '{1, 1'b0, 32'hF000_0000, 32'h0, 4'b0001, 0,  32'h0,  1'b0, 4'b0000, 2,  1'b1, 32'h0};
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Round robin after reset: all request, completions expected 0,1,2,3,0 three cycles apart
    PRST = 1'b1; tick(); PRST = 1'b0; tick();
    mptr = 0;
    for (int k = 0; k < NM; k++) begin
      wait_n[k] = 0; rd_val[k] = 32'h100 + k; se_val[k] = 1'b0;
      bus.PADDR[k] = 32'(k) << 28; bus.PWRITE[k] = 1'b0;
    end
    bus.PSEL = 4'b1111;
    cyc = 0; n = 0; exp_cyc = 2;
    while (n < 5 && cyc < 60) begin
      tick();
      cyc++;
      if (bus.PREADY != '0) begin
        chk("rr_order", 128'(bus.PREADY), 128'(4'b0001 << mptr));
        chk("rr_cycle", 128'(cyc), 128'(exp_cyc));
        chk("rr_prdata", 128'(bus.PRDATA), 128'(32'h100 + mptr) << (32 * mptr));
        mptr = (mptr + 1) % NM;
        exp_cyc = cyc + 3;
        n++;
      end
    end
    chk("rr_count", 128'(n), 128'(5));
    bus.PSEL = '0;
    tick(); tick();

    // Reset during ACCESS, then a fresh request must restart from requester 0
    wait_n[2] = 255;
    bus.PADDR[2] = 32'h2000_0000;
    bus.PSEL = 4'b0100;
    tick(); tick(); tick();
    chk("mid_pre_penable_s", 128'(bus.PENABLE_S), 128'(4'b0100));
    PRST = 1'b1;
    tick();
    chk("mid_psel_s", 128'(bus.PSEL_S), 128'(0));
    chk("mid_penable_s", 128'(bus.PENABLE_S), 128'(0));
    chk("mid_pgrant", 128'(bus.PGRANT), 128'(0));
    chk("mid_pready", 128'(bus.PREADY), 128'(0));
    PRST = 1'b0;
    wait_n[0] = 0; wait_n[1] = 0; wait_n[3] = 0;
    bus.PSEL = 4'b1011;
    tick();
    chk("mid_restart_grant", 128'(bus.PGRANT), 128'(4'b0001));
    bus.PSEL = 4'b0001;
    cyc = 0;
    while (bus.PREADY == '0 && cyc < 10) begin
      tick();
      cyc++;
    end
    chk("mid_restart_pready", 128'(bus.PREADY), 128'(4'b0001));
    bus.PSEL = '0;
    mptr = 1;
    tick(); tick();

    // Randomized rounds against the transaction-level model
    for (int rnd = 0; rnd < 30; rnd++) begin
      pend = 4'($urandom_range(1, 15));
      for (int k = 0; k < NS; k++) begin
        wait_n[k] = ($urandom_range(0, 7) == 0) ? 30 : $urandom_range(0, 3);
        rd_val[k] = $urandom;
        se_val[k] = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < NM; i++) begin
        r_addr[i] = {4'($urandom_range(0, 5)), 28'($urandom)};
        r_wr[i]   = 1'($urandom_range(0, 1));
        bus.PADDR[i]  = r_addr[i];
        bus.PWRITE[i] = r_wr[i];
        bus.PWDATA[i] = $urandom;
        bus.PSTRB[i]  = 4'($urandom);
      end
      bus.PSEL = pend;
      e = next_req(pend, mptr);
      exp_cyc = 1 + acc_of(e);
      cyc = 0;
      while (pend != '0 && cyc < 400) begin
        tick();
        cyc++;
        if (bus.PREADY != '0) begin
          s = int'(r_addr[e][31:28]);
          if (s >= NS) begin
            exp_err = 1'b1; exp_rd = '0;
          end else if (wait_n[s] < TIMEOUT) begin
            exp_err = se_val[s]; exp_rd = r_wr[e] ? 32'h0 : rd_val[s];
          end else begin
            exp_err = 1'b1; exp_rd = '0;
          end
          chk("rnd_order", 128'(bus.PREADY), 128'(4'b0001 << e));
          chk("rnd_cycle", 128'(cyc), 128'(exp_cyc));
          chk("rnd_pslverr", 128'(bus.PSLVERR), 128'(exp_err) << e);
          chk("rnd_prdata", 128'(bus.PRDATA), 128'(exp_rd) << (32 * e));
          chk("rnd_paddr_s", 128'(bus.PADDR_S[0]), 128'(r_addr[e]));
          chk("rnd_pwrite_s", 128'(bus.PWRITE_S), 128'({NS{r_wr[e]}}));
          pend[e] = 1'b0;
          bus.PSEL[e] = 1'b0;
          mptr = (e + 1) % NM;
          if (pend != '0) begin
            e = next_req(pend, mptr);
            exp_cyc = cyc + 2 + acc_of(e);
          end
        end
      end
      chk("rnd_drain", 128'(pend), 128'(0));
      bus.PSEL = '0;
      tick(); tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
